// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, wake-up nibble table and 50 MHz timing defaults for the LCD blocks.
package lcd_pkg;

    typedef enum logic [3:0] {
        S_POWER_WAIT = 4'b0001,
        S_PULSE      = 4'b0010,
        S_GAP        = 4'b0100,
        S_DONE       = 4'b1000
    } lcd_init_state_t;

    localparam logic [3:0] NIB [4] = '{4'h3, 4'h3, 4'h3, 4'h2};

    localparam int T_POWERUP_50M = 750000;
    localparam int T_PULSE_50M   = 12;
    localparam int T_GAP1_50M    = 205000;
    localparam int T_GAP2_50M    = 5000;
    localparam int T_GAP3_50M    = 2000;
    localparam int T_CMD_50M     = 2000;
    localparam int T_CLEAR_50M   = 82000;
    localparam int CNT_W_50M     = 20;

    function automatic logic [3:0] nib_of(input logic [1:0] step);
        return NIB[step];
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: delay timer that restarts on load and flags the last cycle of a len-cycle interval.
module lcd_delay_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    assign expire = count == len - CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= load ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: HD44780 4-bit wake-up sequence (3,3,3,2) with timed gaps, then hands over the bus.
// Define LCD_INIT_FAST_SIM_EN to shorten the power-up and gap waits to 16 cycles.
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int T_POWERUP = T_POWERUP_50M,
    parameter int T_PULSE   = T_PULSE_50M,
    parameter int T_GAP1    = T_GAP1_50M,
    parameter int T_GAP2    = T_GAP2_50M,
    parameter int T_GAP3    = T_GAP3_50M,
    parameter int CNT_W     = CNT_W_50M
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic [3:0] data_init,
    output logic       enable_init,
    output logic       init_done,
    output logic       init_busy
);

`ifdef LCD_INIT_FAST_SIM_EN
    localparam int PWR = 16;
    localparam int G1  = 16;
    localparam int G2  = 16;
    localparam int G3  = 16;
`else
    localparam int PWR = T_POWERUP;
    localparam int G1  = T_GAP1;
    localparam int G2  = T_GAP2;
    localparam int G3  = T_GAP3;
`endif

    lcd_init_state_t  state, state_n;
    logic [1:0]       step, step_n;
    logic             load, expire;
    logic [CNT_W-1:0] len;

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .len    (len),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        step_n  = step;
        len     = state == S_POWER_WAIT ? CNT_W'(PWR) :
                  state == S_PULSE      ? CNT_W'(T_PULSE) :
                  step == 2'd0          ? CNT_W'(G1) :
                  step == 2'd1          ? CNT_W'(G2) : CNT_W'(G3);
        if (restart) begin
            state_n = S_POWER_WAIT;
            step_n  = 2'd0;
        end else if (expire) begin
            case (state)
                S_POWER_WAIT: begin
                    state_n = S_PULSE;
                    step_n  = 2'd0;
                end
                S_PULSE: state_n = S_GAP;
                S_GAP: begin
                    state_n = step == 2'd3 ? S_DONE : S_PULSE;
                    step_n  = step == 2'd3 ? step : step + 2'd1;
                end
                default: ;
            endcase
        end
        // Keep the timer parked while terminal so it never free-runs.
        load = restart | expire | (state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_POWER_WAIT;
            step        <= 2'd0;
            data_init   <= 4'h0;
            enable_init <= 1'b0;
            init_done   <= 1'b0;
            init_busy   <= 1'b1;
        end else begin
            state       <= state_n;
            step        <= step_n;
            data_init   <= (state_n == S_PULSE || state_n == S_GAP) ? nib_of(step_n) : 4'h0;
            enable_init <= state_n == S_PULSE;
            init_done   <= state_n == S_DONE;
            init_busy   <= state_n != S_DONE;
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb_lcd_init_sequencer: scoreboard bench; a timeline model predicts every enable/done edge of lcd_init_sequencer.
module tb_lcd_init_sequencer;

    localparam int TP  = 37;
    localparam int TPL = 12;
    localparam int TG1 = 29;
    localparam int TG2 = 11;
    localparam int TG3 = 7;
    localparam int CW  = 8;

`ifdef LCD_INIT_FAST_SIM_EN
    localparam int EP = 16, EG1 = 16, EG2 = 16, EG3 = 16;
`else
    localparam int EP = TP, EG1 = TG1, EG2 = TG2, EG3 = TG3;
`endif

    localparam int K_RISE = 0, K_FALL = 1, K_DONE = 2, K_UNDONE = 3;
    localparam logic [3:0] MNIB [4] = '{4'h3, 4'h3, 4'h3, 4'h2};

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] nib;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset, restart;
    logic [3:0] data_init;
    logic       enable_init, init_done, init_busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  q[$];
    int   rise_t[4], fall_t[4];
    int   done_t, run_start;

    lcd_init_sequencer #(
        .T_POWERUP (TP),
        .T_PULSE   (TPL),
        .T_GAP1    (TG1),
        .T_GAP2    (TG2),
        .T_GAP3    (TG3),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .data_init   (data_init),
        .enable_init (enable_init),
        .init_done   (init_done),
        .init_busy   (init_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int gap_of(input int k);
        return k == 0 ? EG1 : k == 1 ? EG2 : EG3;
    endfunction

    // Predict the absolute cycle of every observable edge of a run beginning at s.
    task automatic start_run(input int s);
        int t;
        run_start = s;
        t = s + EP;
        for (int k = 0; k < 4; k++) begin
            rise_t[k] = t;
            fall_t[k] = t + TPL;
            q.push_back('{K_RISE, rise_t[k], MNIB[k]});
            q.push_back('{K_FALL, fall_t[k], MNIB[k]});
            t = fall_t[k] + gap_of(k);
        end
        done_t = t;
        q.push_back('{K_DONE, done_t, 4'h0});
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic trim(input int c);
        while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
    endtask

    task automatic do_restart();
        int  c;
        bit  in_pulse;
        c = cyc;
        in_pulse = 0;
        for (int k = 0; k < 4; k++)
            if (rise_t[k] <= c && c < fall_t[k]) in_pulse = 1;
        trim(c);
        if (in_pulse) q.push_back('{K_FALL, c + 1, 4'h0});
        if (done_t <= c) q.push_back('{K_UNDONE, c + 1, 4'h0});
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        start_run(c + 1);
    endtask

    task automatic got(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_data", int'(data_init), int'(e.nib));
        if (kind == K_DONE) chk("busy_at_done", int'(init_busy), 0);
        if (kind == K_UNDONE) chk("busy_at_undone", int'(init_busy), 1);
    endtask

    logic       pe = 1'b0, pd = 1'b0;
    logic [3:0] cur_nib = 4'h0;

    always @(negedge clk) begin
        if (reset) begin
            pe = 1'b0;
            pd = 1'b0;
        end else begin
            if (enable_init !== pe) begin
                if (enable_init && q.size() > 0) cur_nib = q[0].nib;
                got(enable_init ? K_RISE : K_FALL);
            end
            if (init_done !== pd) got(init_done ? K_DONE : K_UNDONE);
            if (enable_init && pe) chk("data_hold", int'(data_init), int'(cur_nib));
            pe = enable_init;
            pd = init_done;
        end
    end

    initial begin
        reset = 1'b1;
        restart = 1'b0;
        #3;
        chk("reset_data", int'(data_init), 0);
        chk("reset_enable", int'(enable_init), 0);
        chk("reset_done", int'(init_done), 0);
        chk("reset_busy", int'(init_busy), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_run(cyc);
        wait_cyc(done_t + 5);

        do_restart();
        wait_cyc(done_t + 5);

        wait_cyc(rise_t[1] + 5);
        do_restart();
        wait_cyc(done_t + 5);

        wait_cyc(fall_t[1] + 3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_data", int'(data_init), 0);
        chk("async_enable", int'(enable_init), 0);
        chk("async_done", int'(init_done), 0);
        chk("async_busy", int'(init_busy), 1);
        trim(cyc);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_run(cyc);
        wait_cyc(done_t + 5);

        repeat (8) begin
            wait_cyc(run_start + int'($urandom_range(0, done_t - run_start + 6)));
            do_restart();
        end
        wait_cyc(done_t + 5);
        chk("leftover_events", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
